bless_inject_ctrl: RTL and testbench

Local-PE injection controller for the bufferless router. It sits on the producer side of the ranked port allocator.
- Queues flits pushed by the PE.
- Injects the head flit into a free router channel whenever the incoming flit count (after ejection) leaves a slot.
- Reports the post-injection flit count that the allocator consumes.
- Tracks injection starvation and raises a throttle flag for the PE.

---
 rtl/bless_inject_ctrl_pkg.sv | 24 ++
 rtl/bless_inject_ctrl_inject_fifo.sv | 49 ++++
 rtl/bless_inject_ctrl.sv | 110 +++++++++++
 tb/tb_bless_inject_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bless_inject_ctrl_pkg.sv
// Shared router widths, injection FSM encoding and the ejection-adjusted flit count helper.
// Purely combinational definitions; no latency or backpressure of its own.
package bless_inject_ctrl_pkg;

  localparam int NUM_PORT       = 5;
  localparam int PC_INDEX_WIDTH = $clog2(NUM_PORT);
  localparam int FLIT_WIDTH     = 64;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    READY   = 2'd1,
    STARVED = 2'd2
  } injState_t;

  // An ejection with no incoming flit is illegal; clamp rather than wrap.
  function automatic logic [PC_INDEX_WIDTH-1:0] remFlits(
    input logic [PC_INDEX_WIDTH-1:0] nIn,
    input logic                      ej
  );
    if (ej && (nIn == '0)) return '0;
    return nIn - PC_INDEX_WIDTH'(ej);
  endfunction

endpackage

// File: rtl/bless_inject_ctrl_inject_fifo.sv
// Injection FIFO: sync write, head read straight from storage (push visible next cycle).
// Caller guarantees no push when full and no pop when empty.
module inject_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             pushFlit,
  input  logic                     pop,
  output logic [W-1:0]             headFlit,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;

  // Pointers are exactly AW bits so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      unique case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushFlit;
  end

  assign headFlit = mem[rdPtr];
  assign full     = (occupancy == (AW+1)'(DEPTH));
  assign empty    = (occupancy == '0);

endmodule

// File: rtl/bless_inject_ctrl.sv
// Local-PE injection controller: queues PE flits, injects the head when a router slot is free,
// zero-latency inject from stored head; pe_ready drops when full; starve flags long blocking.
module bless_inject_ctrl
  import bless_inject_ctrl_pkg::*;
#(
  parameter int FLIT_W    = FLIT_WIDTH,
  parameter int DEPTH     = 8,
  parameter int NUM_CH    = NUM_PORT - 1,
  parameter int STARVE_TH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pe_valid,
  input  logic [FLIT_W-1:0]         pe_flit,
  output logic                      pe_ready,
  input  logic [PC_INDEX_WIDTH-1:0] numFlit_in,
  input  logic                      eject_valid,
  output logic                      inj_valid,
  output logic [FLIT_W-1:0]         inj_flit,
  output logic [PC_INDEX_WIDTH-1:0] numFlit_out,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      starve
);

  localparam int CW = $clog2(STARVE_TH + 1);

  logic [PC_INDEX_WIDTH-1:0] remaining;
  logic                      slotFree;
  logic                      push;
  logic                      full;
  logic                      empty;
  logic                      lastPop;
  injState_t                 stateQ;
  injState_t                 stateNext;
  logic [CW-1:0]             starveCnt;
  logic [CW-1:0]             starveCntNext;

  assign remaining   = remFlits(numFlit_in, eject_valid);
  assign slotFree    = remaining < PC_INDEX_WIDTH'(NUM_CH);
  assign pe_ready    = !reset && !full;
  assign push        = pe_valid && pe_ready;
  assign inj_valid   = !reset && !empty && slotFree;
  assign numFlit_out = remaining + PC_INDEX_WIDTH'(inj_valid);
  assign lastPop     = inj_valid && (occupancy == 1);

  inject_fifo #(
    .W     (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pushFlit  (pe_flit),
    .pop       (inj_valid),
    .headFlit  (inj_flit),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ    <= EMPTY;
      starveCnt <= '0;
    end else begin
      stateQ    <= stateNext;
      starveCnt <= starveCntNext;
    end
  end

  // In READY/STARVED the FIFO is nonempty, so !inj_valid means the slot test blocked us.
  always_comb begin
    stateNext     = stateQ;
    starveCntNext = starveCnt;
    unique case (stateQ)
      EMPTY: begin
        starveCntNext = '0;
        if (push) stateNext = READY;
      end
      READY: begin
        if (inj_valid) begin
          starveCntNext = '0;
          if (lastPop && !push) stateNext = EMPTY;
        end else if (starveCnt == CW'(STARVE_TH - 1)) begin
          stateNext = STARVED;
        end else begin
          starveCntNext = starveCnt + 1'b1;
        end
      end
      STARVED: begin
        if (inj_valid) begin
          starveCntNext = '0;
          stateNext     = (lastPop && !push) ? EMPTY : READY;
        end
      end
      default: begin
        stateNext     = EMPTY;
        starveCntNext = '0;
      end
    endcase
  end

  always_comb begin
    starve = (stateQ == STARVED);
  end

  illegalEject: assert property (@(posedge clk) disable iff (reset)
    !(eject_valid && (numFlit_in == '0)));

endmodule

// File: tb/tb_bless_inject_ctrl.sv
// Randomized + directed bench: reference queue model produces per-cycle expectations, a negedge monitor checks them.
module tb_bless_inject_ctrl;
  import bless_inject_ctrl_pkg::*;

  localparam int FW     = 64;
  localparam int DEPTH  = 8;
  localparam int NUM_CH = 4;
  localparam int TH     = 16;
  localparam int PW     = PC_INDEX_WIDTH;
  localparam int OW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pe_valid = 1'b0;
  logic [FW-1:0] pe_flit = '0;
  logic          pe_ready;
  logic [PW-1:0] numFlit_in = '0;
  logic          eject_valid = 1'b0;
  logic          inj_valid;
  logic [FW-1:0] inj_flit;
  logic [PW-1:0] numFlit_out;
  logic [OW-1:0] occupancy;
  logic          starve;

  bless_inject_ctrl #(
    .FLIT_W    (FW),
    .DEPTH     (DEPTH),
    .NUM_CH    (NUM_CH),
    .STARVE_TH (TH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pe_valid    (pe_valid),
    .pe_flit     (pe_flit),
    .pe_ready    (pe_ready),
    .numFlit_in  (numFlit_in),
    .eject_valid (eject_valid),
    .inj_valid   (inj_valid),
    .inj_flit    (inj_flit),
    .numFlit_out (numFlit_out),
    .occupancy   (occupancy),
    .starve      (starve)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          injV;
    logic [FW-1:0] flit;
    int          nfo;
    int          occ;
    bit          rdy;
    bit          starve;
  } exp_t;

  exp_t          expQ[$];
  logic [FW-1:0] mq[$];
  int            streak = 0;
  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;

  task automatic chk(string nm, int c, logic [FW-1:0] act, logic [FW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h want %0h", nm, c, act, req);
    end
  endtask

  // Model: a plain queue of flits; starve is high once the last TH cycles were all "nonempty and blocked".
  task automatic step(bit pv, logic [FW-1:0] pf, int nin, bit ej, bit rst);
    exp_t e;
    int   rem;
    @(posedge clk);
    #1;
    reset       = rst;
    pe_valid    = pv;
    pe_flit     = pf;
    numFlit_in  = PW'(nin);
    eject_valid = ej;
    rem         = (nin == 0) ? 0 : nin - int'(ej);
    e.cyc  = cyc;
    e.flit = '0;
    if (rst) begin
      mq.delete();
      streak   = 0;
      e.injV   = 1'b0;
      e.occ    = 0;
      e.rdy    = 1'b0;
      e.starve = 1'b0;
      e.nfo    = rem;
    end else begin
      e.injV   = (mq.size() > 0) && (rem < NUM_CH);
      e.rdy    = mq.size() < DEPTH;
      e.occ    = mq.size();
      e.starve = streak >= TH;
      e.nfo    = rem + int'(e.injV);
      if (e.injV) e.flit = mq[0];
      if (mq.size() == 0 || e.injV) streak = 0;
      else if (streak < TH) streak++;
      if (e.injV) void'(mq.pop_front());
      if (pv && e.rdy) mq.push_back(pf);
    end
    expQ.push_back(e);
    cyc++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("inj_valid",   e.cyc, FW'(inj_valid),   FW'(e.injV));
      chk("pe_ready",    e.cyc, FW'(pe_ready),    FW'(e.rdy));
      chk("occupancy",   e.cyc, FW'(occupancy),   FW'(e.occ));
      chk("numFlit_out", e.cyc, FW'(numFlit_out), FW'(e.nfo));
      chk("starve",      e.cyc, FW'(starve),      FW'(e.starve));
      if (e.injV) chk("inj_flit", e.cyc, inj_flit, e.flit);
    end
  end

  function automatic logic [FW-1:0] rndFlit();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    int nin;
    bit ej;
    // Reset held with a push request pending.
    step(1'b1, 64'h11, 2, 1'b0, 1'b1);
    step(1'b1, 64'h11, 2, 1'b0, 1'b1);
    step(1'b1, 64'h77, 2, 1'b0, 1'b0);
    step(1'b0, 64'h0,  2, 1'b0, 1'b0);
    // Single flit with a free slot.
    step(1'b1, 64'hA5, 2, 1'b0, 1'b0);
    step(1'b0, 64'h0,  2, 1'b0, 1'b0);
    step(1'b0, 64'h0,  2, 1'b0, 1'b0);
    // Full-load channels: ejection frees a slot, no ejection blocks.
    step(1'b1, 64'hB1, 4, 1'b0, 1'b0);
    step(1'b0, 64'h0,  4, 1'b1, 1'b0);
    step(1'b1, 64'hB2, 4, 1'b0, 1'b0);
    step(1'b0, 64'h0,  4, 1'b0, 1'b0);
    step(1'b0, 64'h0,  3, 1'b0, 1'b0);
    // Fill to DEPTH under full load, one refused push, then drain in order.
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 64'hC0 + FW'(i), 4, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 64'h0, 0, 1'b0, 1'b0);
    // Starvation: one flit blocked for TH+1 cycles, then released.
    step(1'b1, 64'hD1, 4, 1'b0, 1'b0);
    for (int i = 0; i < TH + 1; i++) step(1'b0, 64'h0, 4, 1'b0, 1'b0);
    step(1'b0, 64'h0, 3, 1'b0, 1'b0);
    step(1'b0, 64'h0, 3, 1'b0, 1'b0);
    // Reset mid-burst discards queued flits.
    for (int i = 0; i < 5; i++) step(1'b1, 64'hE0 + FW'(i), 4, 1'b0, 1'b0);
    step(1'b1, 64'hEE, 4, 1'b0, 1'b1);
    step(1'b1, 64'h3C, 2, 1'b0, 1'b0);
    step(1'b0, 64'h0,  2, 1'b0, 1'b0);
    step(1'b0, 64'h0,  2, 1'b0, 1'b0);
    // Random phases with varying channel pressure.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 99) < 30 + ph * 20) nin = 4;
        else nin = $urandom_range(0, 4);
        ej = (nin > 0) && ($urandom_range(0, 3) == 0);
        step($urandom_range(0, 2) != 0, rndFlit(), nin, ej,
             $urandom_range(0, 199) == 0);
      end
    end
    step(1'b0, 64'h0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (expQ.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
